// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller and the pipeline registers.
package hazard_ctrl_pkg;

    localparam int REG_W   = 3;
    localparam int LAT_W   = 4;
    localparam int INSTR_W = 16;

    // All-zero word doubles as the NOP/bubble loaded into flushed stage registers.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    function automatic logic reg_hazard(
        input logic             ex_valid,
        input logic             ex_mem_read,
        input logic [REG_W-1:0] ex_dest,
        input logic [REG_W-1:0] id_src,
        input logic             id_uses_src,
        input logic [REG_W-1:0] id_dest,
        input logic             id_uses_dest
    );
        logic src_hit;
        logic dest_hit;
        src_hit  = id_uses_src  & (id_src  == ex_dest);
        dest_hit = id_uses_dest & (id_dest == ex_dest);
        return ex_valid & ex_mem_read & (src_hit | dest_hit);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller's performance statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count up on inc, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: load-use bubbles, branch squashing and data-memory freezes
// for the 5-stage pipeline, plus saturating stall/flush statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_src,
    input  logic [2:0]       id_dest,
    input  logic             id_uses_src,
    input  logic             id_uses_dest,
    input  logic [2:0]       ex_dest,
    input  logic             ex_mem_read,
    input  logic             ex_valid,
    input  logic             branch_taken,
    input  logic             mem_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The access instruction stays in MEM for MEM_LAT cycles; the last one is the release cycle.
    localparam logic             FREEZE_EN = (MEM_LAT > 1) ? 1'b1 : 1'b0;
    localparam logic [LAT_W-1:0] CNT_INIT  = (MEM_LAT > 1) ? LAT_W'(MEM_LAT - 2) : 4'd0;

    state_e           state_r;
    state_e           state_nx_s;
    logic [LAT_W-1:0] cnt_r;
    logic [LAT_W-1:0] cnt_nx_s;
    logic             freeze_s;
    logic             loaduse_s;
    logic             branch_flush_s;
    logic             stall_inc_s;

    assign loaduse_s = reg_hazard(ex_valid, ex_mem_read, ex_dest,
                                  id_src, id_uses_src, id_dest, id_uses_dest);

    // Freeze source: a new access in RUN, or remaining wait cycles in MEM_WAIT.
    always_comb begin
        freeze_s = 1'b0;
        case (state_r)
            RUN:      freeze_s = FREEZE_EN & mem_start;
            MEM_WAIT: freeze_s = (cnt_r != 4'd0);
            default:  freeze_s = 1'b0;
        endcase
    end

    assign branch_flush_s = ~rst & ~freeze_s & branch_taken;

    // State and wait-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next state; the release cycle ignores mem_start because the same access is still in MEM.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            RUN: begin
                if (freeze_s) begin
                    state_nx_s = MEM_WAIT;
                    cnt_nx_s   = CNT_INIT;
                end else begin
                    state_nx_s = RUN;
                    cnt_nx_s   = cnt_r;
                end
            end
            MEM_WAIT: begin
                if (cnt_r != 4'd0) begin
                    state_nx_s = MEM_WAIT;
                    cnt_nx_s   = cnt_r - 4'd1;
                end else begin
                    state_nx_s = RUN;
                    cnt_nx_s   = 4'd0;
                end
            end
            default: begin
                state_nx_s = RUN;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // Stage enables: reset > freeze > branch flush > load-use bubble > free run.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (loaduse_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    assign busy        = ~rst & (state_r == MEM_WAIT);
    assign stall_inc_s = ~rst & ~pc_write;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_flush_s),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MEM_LAT=3 and MEM_LAT=4 instances.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_src, id_dest, ex_dest;
    logic       id_uses_src, id_uses_dest, ex_mem_read, ex_valid, branch_taken, mem_start;

    logic        pc_write3, ifid_write3, ifid_flush3, idex_write3, idex_flush3;
    logic        exmem_write3, memwb_bubble3, busy3;
    logic [15:0] stall_cnt3, flush_cnt3;
    logic        pc_write4, ifid_write4, ifid_flush4, idex_write4, idex_flush4;
    logic        exmem_write4, memwb_bubble4, busy4;
    logic [15:0] stall_cnt4, flush_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_LAT(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .id_src(id_src), .id_dest(id_dest),
        .id_uses_src(id_uses_src), .id_uses_dest(id_uses_dest), .ex_dest(ex_dest),
        .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .branch_taken(branch_taken),
        .mem_start(mem_start), .pc_write(pc_write3), .ifid_write(ifid_write3),
        .ifid_flush(ifid_flush3), .idex_write(idex_write3), .idex_flush(idex_flush3),
        .exmem_write(exmem_write3), .memwb_bubble(memwb_bubble3), .busy(busy3),
        .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
    );

    hazard_ctrl #(.MEM_LAT(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .id_src(id_src), .id_dest(id_dest),
        .id_uses_src(id_uses_src), .id_uses_dest(id_uses_dest), .ex_dest(ex_dest),
        .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .branch_taken(branch_taken),
        .mem_start(mem_start), .pc_write(pc_write4), .ifid_write(ifid_write4),
        .ifid_flush(ifid_flush4), .idex_write(idex_write4), .idex_flush(idex_flush4),
        .exmem_write(exmem_write4), .memwb_bubble(memwb_bubble4), .busy(busy4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_src = 3'd0; id_dest = 3'd0; ex_dest = 3'd0;
        id_uses_src = 1'b0; id_uses_dest = 1'b0; ex_mem_read = 1'b0;
        ex_valid = 1'b0; branch_taken = 1'b0; mem_start = 1'b0;
    endtask

    task automatic set_loaduse_src();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_dest = 3'd3;
        id_src = 3'd3; id_uses_src = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        chk_eq("rst_pc_write",   {31'd0, pc_write3},     32'd0);
        chk_eq("rst_exmem",      {31'd0, exmem_write3},  32'd0);
        chk_eq("rst_ifid_flush", {31'd0, ifid_flush3},   32'd1);
        chk_eq("rst_idex_flush", {31'd0, idex_flush3},   32'd1);
        chk_eq("rst_memwb",      {31'd0, memwb_bubble3}, 32'd1);
        chk_eq("rst_busy",       {31'd0, busy3},         32'd0);

        @(negedge clk); rst = 1'b0; #1;
        chk_eq("run_pc_write",   {31'd0, pc_write3},     32'd1);
        chk_eq("run_ifid_write", {31'd0, ifid_write3},   32'd1);
        chk_eq("run_idex_write", {31'd0, idex_write3},   32'd1);
        chk_eq("run_exmem",      {31'd0, exmem_write3},  32'd1);
        chk_eq("run_flushes",    {30'd0, ifid_flush3, idex_flush3}, 32'd0);
        chk_eq("run_memwb",      {31'd0, memwb_bubble3}, 32'd0);
        chk_eq("run_stall_cnt",  {16'd0, stall_cnt3},    32'd0);
        chk_eq("run_flush_cnt",  {16'd0, flush_cnt3},    32'd0);

        // Load-use on the src operand.
        @(negedge clk); set_loaduse_src(); #1;
        chk_eq("lu_pc_write",   {31'd0, pc_write3},   32'd0);
        chk_eq("lu_ifid_write", {31'd0, ifid_write3}, 32'd0);
        chk_eq("lu_idex_flush", {31'd0, idex_flush3}, 32'd1);
        chk_eq("lu_idex_write", {31'd0, idex_write3}, 32'd1);
        chk_eq("lu_exmem",      {31'd0, exmem_write3}, 32'd1);
        chk_eq("lu_ifid_flush", {31'd0, ifid_flush3}, 32'd0);

        @(negedge clk); id_uses_src = 1'b0; #1;
        chk_eq("lu_stall_cnt",   {16'd0, stall_cnt3}, 32'd1);
        chk_eq("nouse_pc_write", {31'd0, pc_write3},  32'd1);

        @(negedge clk); id_uses_src = 1'b1; ex_valid = 1'b0; #1;
        chk_eq("noval_pc_write", {31'd0, pc_write3},  32'd1);

        // Load-use on the dest operand.
        @(negedge clk); clear_inputs();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_dest = 3'd5; id_dest = 3'd5; id_uses_dest = 1'b1; #1;
        chk_eq("lud_pc_write",   {31'd0, pc_write3},   32'd0);
        chk_eq("lud_idex_flush", {31'd0, idex_flush3}, 32'd1);

        @(negedge clk); clear_inputs(); #1;
        chk_eq("lud_stall_cnt", {16'd0, stall_cnt3}, 32'd2);

        // MEM_LAT=3 freeze with a branch held from the first freeze cycle.
        @(negedge clk); mem_start = 1'b1; branch_taken = 1'b1; #1;
        chk_eq("fz0_pc_write",   {31'd0, pc_write3},     32'd0);
        chk_eq("fz0_exmem",      {31'd0, exmem_write3},  32'd0);
        chk_eq("fz0_memwb",      {31'd0, memwb_bubble3}, 32'd1);
        chk_eq("fz0_ifid_flush", {31'd0, ifid_flush3},   32'd0);
        chk_eq("fz0_busy",       {31'd0, busy3},         32'd0);
        @(negedge clk); #1;
        chk_eq("fz1_busy",       {31'd0, busy3},         32'd1);
        chk_eq("fz1_pc_write",   {31'd0, pc_write3},     32'd0);
        chk_eq("fz1_idex_flush", {31'd0, idex_flush3},   32'd0);
        @(negedge clk); #1;
        chk_eq("rel_busy",       {31'd0, busy3},         32'd1);
        chk_eq("rel_pc_write",   {31'd0, pc_write3},     32'd1);
        chk_eq("rel_exmem",      {31'd0, exmem_write3},  32'd1);
        chk_eq("rel_memwb",      {31'd0, memwb_bubble3}, 32'd0);
        chk_eq("rel_ifid_flush", {31'd0, ifid_flush3},   32'd1);
        chk_eq("rel_idex_flush", {31'd0, idex_flush3},   32'd1);
        @(negedge clk); clear_inputs(); #1;
        chk_eq("post_busy",      {31'd0, busy3},         32'd0);
        chk_eq("fz_stall_cnt",   {16'd0, stall_cnt3},    32'd4);
        chk_eq("fz_flush_cnt",   {16'd0, flush_cnt3},    32'd1);

        // Branch together with a load-use match: flush wins.
        @(negedge clk); set_loaduse_src(); branch_taken = 1'b1; #1;
        chk_eq("brlu_pc_write",   {31'd0, pc_write3},   32'd1);
        chk_eq("brlu_ifid_write", {31'd0, ifid_write3}, 32'd1);
        chk_eq("brlu_ifid_flush", {31'd0, ifid_flush3}, 32'd1);
        @(negedge clk); clear_inputs(); #1;
        chk_eq("brlu_stall_cnt", {16'd0, stall_cnt3}, 32'd4);
        chk_eq("brlu_flush_cnt", {16'd0, flush_cnt3}, 32'd2);

        // MEM_LAT=4 freeze aborted by reset on its second cycle.
        @(negedge clk); mem_start = 1'b1; #1;
        chk_eq("m4_fz0_busy",     {31'd0, busy4},     32'd0);
        chk_eq("m4_fz0_pc_write", {31'd0, pc_write4}, 32'd0);
        @(negedge clk); #1;
        chk_eq("m4_fz1_busy",     {31'd0, busy4},     32'd1);
        rst = 1'b1; #1;
        chk_eq("m4_rst_busy",      {31'd0, busy4},      32'd0);
        chk_eq("m4_rst_stall_cnt", {16'd0, stall_cnt4}, 32'd0);
        chk_eq("m4_rst_flush_cnt", {16'd0, flush_cnt4}, 32'd0);
        chk_eq("m4_rst_memwb",     {31'd0, memwb_bubble4}, 32'd1);
        @(negedge clk); rst = 1'b0; clear_inputs(); #1;
        chk_eq("m4_after_busy",     {31'd0, busy4},        32'd0);
        chk_eq("m4_after_pc_write", {31'd0, pc_write4},    32'd1);
        chk_eq("m4_after_ifid",     {31'd0, ifid_write4},  32'd1);
        chk_eq("m4_after_idex",     {31'd0, idex_write4},  32'd1);
        chk_eq("m4_after_exmem",    {31'd0, exmem_write4}, 32'd1);
        chk_eq("m4_after_memwb",    {31'd0, memwb_bubble4}, 32'd0);
        chk_eq("m4_after_flushes",  {30'd0, ifid_flush4, idex_flush4}, 32'd0);
        @(negedge clk); #1;
        chk_eq("m4_run_busy",      {31'd0, busy4},      32'd0);
        chk_eq("m4_run_stall_cnt", {16'd0, stall_cnt4}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
